// File: rtl/instr_fetch_pkg.sv
// Shared fetch-sequencer definitions: the state encoding is reused by the CPU sequencer.
package instr_fetch_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one word per PC value from the ROM and buffers it
// until the CPU takes it, dropping responses made stale by a jump (flush).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               flush,
  output logic               rom_req,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               pc_inc
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instrAddr_q, instrAddr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      instr_q     <= '0;
      instrAddr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      instrAddr_q <= instrAddr_d;
    end
  end

  // Every entry into REQ captures the fetch address; a started ROM read is never
  // aborted, so a flush mid-read waits in DISCARD for the ack before refetching.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    instrAddr_d = instrAddr_q;
    rom_req     = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        addr_d  = pc;
      end
      REQ: begin
        rom_req = 1'b1;
        if (rom_ack && flush) begin
          addr_d = pc;
        end else if (rom_ack) begin
          instr_d     = rom_data;
          instrAddr_d = addr_q;
          state_d     = HOLD;
        end else if (flush) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        rom_req = 1'b1;
        if (rom_ack) begin
          state_d = REQ;
          addr_d  = pc;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (flush) begin
          state_d = REQ;
          addr_d  = pc;
        end else if (instr_ready) begin
          // The PC increments on this same edge, so fetch its post-increment value.
          state_d = REQ;
          addr_d  = pc + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pc_inc     = instr_valid & instr_ready & ~flush;
  assign rom_addr   = addr_q;
  assign instr      = instr_q;
  assign instr_addr = instrAddr_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, giving the instruction address width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port pc, input, ADDR_W bits: current program-counter value, the address to fetch.
REQ-005 The block SHALL have port flush, input, 1 bit: PC was loaded (jump) this cycle; in-flight or held instruction is stale.
REQ-006 The block SHALL have port rom_req, output, 1 bit: read request to instruction ROM.
REQ-007 The block SHALL have port rom_addr, output, ADDR_W bits: ROM read address, valid while rom_req=1.
REQ-008 The block SHALL have port rom_ack, input, 1 bit: ROM read completion; rom_data is valid in the same cycle.
REQ-009 The block SHALL have port rom_data, input, 16 bits: instruction word from ROM.
REQ-010 The block SHALL have port instr, output, 16 bits: buffered instruction presented to the CPU.
REQ-011 The block SHALL have port instr_addr, output, ADDR_W bits: address that instr was fetched from.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: instr/instr_addr hold a live instruction.
REQ-013 The block SHALL have port instr_ready, input, 1 bit: CPU accepts instr this cycle.
REQ-014 The block SHALL have port pc_inc, output, 1 bit: drives the PC inc input; one pulse per accepted instruction.

Function
REQ-015 The FSM SHALL have four states: IDLE, REQ, DISCARD, HOLD.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-017 In REQ: rom_req=1 and rom_addr=pc registered on entry; rom_addr SHALL stay stable until rom_ack.
REQ-018 REQ with rom_ack=1 and flush=0: latch rom_data into instr and rom_addr into instr_addr, go to HOLD.
REQ-019 REQ with flush=1 and rom_ack=0: keep rom_req/rom_addr unchanged (no abort), go to DISCARD.
REQ-020 REQ with flush=1 and rom_ack=1 in the same cycle: drop the data, go to REQ with the new pc next cycle.
REQ-021 In DISCARD: rom_req=1, same rom_addr; on rom_ack, drop the data and go to REQ, capturing the current pc.
REQ-022 In HOLD: instr_valid=1; instr and instr_addr SHALL be stable until handshake or flush.
REQ-023 pc_inc SHALL equal instr_valid & instr_ready & ~flush, combinationally.
REQ-024 HOLD with instr_ready=1 and flush=0: pc_inc=1, go to REQ; next rom_addr = pc + 1, the PC's post-increment value.
REQ-025 HOLD with flush=1, regardless of instr_ready: instr_valid=0 next cycle, pc_inc=0, go to REQ.
REQ-026 instr_valid SHALL be 0 in every state other than HOLD.
REQ-027 Throughput: with a ROM acking in the first REQ cycle, the block SHALL sustain one instruction per 2 cycles.
REQ-028 Address wrap-around: pc = 2^ADDR_W-1 SHALL be fetched normally; no special case is required.

Reset
REQ-029 Reset asserted SHALL force state to IDLE immediately, regardless of clock.
REQ-030 While reset is asserted, outputs SHALL be: rom_req=0, rom_addr=0, instr=0, instr_addr=0, instr_valid=0, pc_inc=0.
REQ-031 Reset asserted mid-request SHALL abandon the request; a late rom_ack after reset release, while in IDLE, SHALL be ignored.

Structure
REQ-032 State encodings (2-bit IDLE=0, REQ=1, DISCARD=2, HOLD=3) SHALL live in the shared hack package/include, for reuse by the CPU sequencer.
REQ-033 The block SHALL be a single flat module with no sub-module; the buffer registers are local, since they need asynchronous reset.

Verification
REQ-034 Reset, then pc=0 with a ROM acking after 1 cycle holding 0x1234 -> instr=0x1234, instr_addr=0, instr_valid=1, rom_req=0.
REQ-035 ready always 1, ROM 0-wait, PC model incrementing on pc_inc -> rom_addr sequence 0,1,2,3 at one instruction per 2 cycles; pc_inc pulses 1 cycle each.
REQ-036 ROM 3-wait, flush plus pc=0x0100 in the second REQ cycle -> DISCARD; first ack data dropped (no instr_valid); next rom_addr=0x0100.
REQ-037 HOLD with instr_ready=1 and flush=1 same cycle -> pc_inc=0, instr_valid falls, next rom_addr = new pc.
REQ-038 HOLD, instr_ready=0 for 5 cycles -> instr, instr_addr stable, instr_valid=1, pc_inc=0, rom_req=0 throughout.
REQ-039 reset pulsed asynchronously during REQ with rom_ack arriving 1 cycle after release -> ack ignored, fetch restarts at pc=0 after IDLE.
